// File: rtl/spi_flash_master.sv
// spi_flash_master: memory-mapped SPI mode-0 byte shifter (MSB first) for the j1 IO bus.
// Define SPI_FLASH_IRQ_EN to build the one-cycle completion pulse on irq; otherwise irq is tied low.
module spi_flash_master #(
    parameter logic [15:0] ADDR_DATA = 16'd320,
    parameter logic [15:0] ADDR_CTRL = 16'd321,
    parameter int unsigned CLKDIV    = 0
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [15:0] mem_addr,
    input  logic [15:0] dout,
    output logic [15:0] rdata,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n,
    output logic        busy,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLKDIV);

    state_t      state_reg;
    logic [7:0]  div_reg;
    logic [2:0]  bit_reg;
    logic [7:0]  shift_reg;
    logic [7:0]  rx_reg;
    logic        sck_reg;
    logic        mosi_reg;
    logic        cs_n_reg;
    logic        data_wr;
    logic        ctrl_wr;
    logic        unused_bits;

    // The read strobe carries no side effects; upper write bits are don't-care.
    assign unused_bits = &{1'b0, io_rd, dout[15:8]};

    assign data_wr  = io_wr && (mem_addr == ADDR_DATA);
    assign ctrl_wr  = io_wr && (mem_addr == ADDR_CTRL);
    assign spi_sck  = sck_reg;
    assign spi_mosi = mosi_reg;
    assign spi_cs_n = cs_n_reg;
    assign busy     = (state_reg != IDLE);

`ifdef SPI_FLASH_IRQ_EN
    logic irq_reg;
    assign irq = irq_reg;
`else
    assign irq = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_reg <= IDLE;
            div_reg   <= 8'd0;
            bit_reg   <= 3'd0;
            shift_reg <= 8'd0;
            rx_reg    <= 8'd0;
            sck_reg   <= 1'b0;
            mosi_reg  <= 1'b0;
            cs_n_reg  <= 1'b1;
`ifdef SPI_FLASH_IRQ_EN
            irq_reg   <= 1'b0;
`endif
        end else begin
`ifdef SPI_FLASH_IRQ_EN
            irq_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    sck_reg <= 1'b0;
                    if (data_wr) begin
                        shift_reg <= dout[7:0];
                        mosi_reg  <= dout[7];
                        div_reg   <= DIV_LOAD;
                        bit_reg   <= 3'd0;
                        state_reg <= LO;
                    end else if (ctrl_wr) begin
                        cs_n_reg <= ~dout[0];
                    end
                end
                LO: begin
                    if (div_reg == 8'd0) begin
                        // Rising SCK: capture MISO into the LSB as the shifter advances.
                        sck_reg   <= 1'b1;
                        shift_reg <= {shift_reg[6:0], spi_miso};
                        div_reg   <= DIV_LOAD;
                        state_reg <= HI;
                    end else begin
                        div_reg <= div_reg - 8'd1;
                    end
                end
                HI: begin
                    if (div_reg == 8'd0) begin
                        sck_reg <= 1'b0;
                        div_reg <= DIV_LOAD;
                        bit_reg <= bit_reg + 3'd1;
                        if (bit_reg == 3'd7) begin
                            state_reg <= DONE;
`ifdef SPI_FLASH_IRQ_EN
                            irq_reg   <= 1'b1;
`endif
                        end else begin
                            // Falling SCK: the already-shifted MSB is the next outgoing bit.
                            mosi_reg  <= shift_reg[7];
                            state_reg <= LO;
                        end
                    end else begin
                        div_reg <= div_reg - 8'd1;
                    end
                end
                DONE: begin
                    rx_reg    <= shift_reg;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = 16'd0;
        if (mem_addr == ADDR_DATA)
            rdata = {8'h00, rx_reg};
        else if (mem_addr == ADDR_CTRL)
            rdata = {14'd0, ~cs_n_reg, busy};
    end
endmodule

// File: tb/tb_spi_flash_master.sv
// Bench for spi_flash_master: two instances (CLKDIV=0 and CLKDIV=3), table vectors, random transfers
// and hand-written CS framing, ignored-write, back-to-back and reset-abort sequences.
module tb_spi_flash_master;
    localparam logic [15:0] A_DATA = 16'd320;
    localparam logic [15:0] A_CTRL = 16'd321;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        io_wr    [2];
    logic        io_rd    [2];
    logic [15:0] mem_addr [2];
    logic [15:0] dout     [2];
    logic [15:0] rdata    [2];
    logic        sck      [2];
    logic        mosi     [2];
    logic        miso     [2];
    logic        cs_n     [2];
    logic        busy     [2];
    logic        irq      [2];

    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    spi_flash_master #(.CLKDIV(0)) dut0 (
        .clk(clk), .resetq(resetq), .io_wr(io_wr[0]), .io_rd(io_rd[0]), .mem_addr(mem_addr[0]),
        .dout(dout[0]), .rdata(rdata[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]),
        .spi_cs_n(cs_n[0]), .busy(busy[0]), .irq(irq[0])
    );

    spi_flash_master #(.CLKDIV(3)) dut3 (
        .clk(clk), .resetq(resetq), .io_wr(io_wr[1]), .io_rd(io_rd[1]), .mem_addr(mem_addr[1]),
        .dout(dout[1]), .rdata(rdata[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]),
        .spi_cs_n(cs_n[1]), .busy(busy[1]), .irq(irq[1])
    );

    typedef struct {
        int         busy_cyc;
        int         rises;
        logic [7:0] mosi_bits;
        int         lo_min, lo_max, hi_min, hi_max;
        int         irq_cnt;
        int         irq_at;
        int         cs_changed;
        int         glitch;
        int         timeout;
    } meas_t;

    typedef struct {
        int         k;
        logic [7:0] tx;
        logic [7:0] mpat;
        bit         loopb;
        logic [7:0] exp_rx;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic rd(input int k, input logic [15:0] a, output logic [15:0] v);
        mem_addr[k] = a;
        #1;
        v = rdata[k];
    endtask

    task automatic wr(input int k, input logic [15:0] a, input logic [15:0] d);
        io_wr[k] = 1'b1;
        mem_addr[k] = a;
        dout[k] = d;
        @(negedge clk);
        io_wr[k] = 1'b0;
    endtask

    // Issues a data write and watches the transfer cycle by cycle until busy drops.
    task automatic run_xfer(input int k, input logic [7:0] tx, input logic [7:0] mpat, input bit loopb,
                            input int inj_at, input logic [15:0] inj_addr, input logic [15:0] inj_data,
                            output meas_t m);
        logic prev_sck;
        logic cs0;
        int   run;
        m = '{default: 0};
        m.lo_min = 1000;
        m.hi_min = 1000;
        cs0 = cs_n[k];
        miso[k] = loopb ? tx[7] : mpat[7];
        wr(k, A_DATA, {8'h5A, tx});
        prev_sck = 1'b0;
        run = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (!busy[k]) break;
            m.busy_cyc++;
            if (cs_n[k] != cs0) m.cs_changed = 1;
            if (irq[k]) begin
                m.irq_cnt++;
                m.irq_at = m.busy_cyc;
            end
            if (sck[k] != prev_sck) begin
                if (prev_sck) begin
                    m.hi_min = (run < m.hi_min) ? run : m.hi_min;
                    m.hi_max = (run > m.hi_max) ? run : m.hi_max;
                end else begin
                    m.lo_min = (run < m.lo_min) ? run : m.lo_min;
                    m.lo_max = (run > m.lo_max) ? run : m.lo_max;
                end
                if (sck[k]) begin
                    m.mosi_bits = {m.mosi_bits[6:0], mosi[k]};
                    m.rises++;
                end
                run = 1;
            end else begin
                run++;
                if (sck[k] && (mosi[k] != m.mosi_bits[0])) m.glitch++;
            end
            prev_sck = sck[k];
            if (loopb)
                miso[k] = mosi[k];
            else
                miso[k] = (m.rises < 8) ? mpat[7 - m.rises] : 1'b0;
            if (m.busy_cyc == inj_at) begin
                io_wr[k] = 1'b1;
                mem_addr[k] = inj_addr;
                dout[k] = inj_data;
            end else begin
                io_wr[k] = 1'b0;
            end
            @(negedge clk);
        end
        io_wr[k] = 1'b0;
        m.timeout = int'(busy[k]);
    endtask

    // Reference: every phase is CLKDIV+1 cycles, 16 phases plus one DONE cycle, MOSI carries tx MSB first.
    task automatic verify(input string nm, input int k, input logic [7:0] tx, input logic [7:0] exp_rx,
                          input logic [15:0] exp_ctrl, input meas_t m);
        int h;
        logic [15:0] v;
        h = (k == 0) ? 1 : 4;
        check({nm, ".timeout"}, m.timeout, 0);
        check({nm, ".busy_cycles"}, m.busy_cyc, 16 * h + 1);
        check({nm, ".sck_rises"}, m.rises, 8);
        check({nm, ".mosi_bits"}, int'(m.mosi_bits), int'(tx));
        check({nm, ".lo_min"}, m.lo_min, h);
        check({nm, ".lo_max"}, m.lo_max, h);
        check({nm, ".hi_min"}, m.hi_min, h);
        check({nm, ".hi_max"}, m.hi_max, h);
        check({nm, ".mosi_stable"}, m.glitch, 0);
`ifdef SPI_FLASH_IRQ_EN
        check({nm, ".irq_count"}, m.irq_cnt, 1);
        check({nm, ".irq_at_last_busy"}, m.irq_at, 16 * h + 1);
`else
        check({nm, ".irq_count"}, m.irq_cnt, 0);
`endif
        rd(k, A_DATA, v);
        check({nm, ".rx_read"}, int'(v), int'({8'h00, exp_rx}));
        rd(k, A_CTRL, v);
        check({nm, ".ctrl_read"}, int'(v), int'(exp_ctrl));
        $display("xfer %s dut%0d tx=%02h rx_exp=%02h busy=%0d rises=%0d", nm, k, tx, exp_rx, m.busy_cyc, m.rises);
    endtask

    initial begin
        vec_t        tbl [6];
        meas_t       m;
        logic [15:0] v;
        logic [7:0]  tx, mp;
        bit          lb;
        int          k, n;
        logic        prev;

        for (int i = 0; i < 2; i++) begin
            io_wr[i] = 1'b0; io_rd[i] = 1'b0; mem_addr[i] = 16'd0; dout[i] = 16'd0; miso[i] = 1'b0;
        end
        tbl = '{
            '{0, 8'hA5, 8'h00, 1'b1, 8'hA5},
            '{1, 8'h3C, 8'hFF, 1'b0, 8'hFF},
            '{0, 8'h00, 8'hFF, 1'b0, 8'hFF},
            '{0, 8'hFF, 8'h00, 1'b0, 8'h00},
            '{1, 8'h81, 8'h5A, 1'b0, 8'h5A},
            '{1, 8'h96, 8'h00, 1'b1, 8'h96}
        };

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset.sck", int'(sck[i]), 0);
            check("reset.mosi", int'(mosi[i]), 0);
            check("reset.cs_n", int'(cs_n[i]), 1);
            check("reset.busy", int'(busy[i]), 0);
            check("reset.irq", int'(irq[i]), 0);
            rd(i, A_DATA, v);
            check("reset.rx", int'(v), 0);
        end
        resetq = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_xfer(tbl[i].k, tbl[i].tx, tbl[i].mpat, tbl[i].loopb, 0, 16'd0, 16'd0, m);
            verify($sformatf("tbl%0d", i), tbl[i].k, tbl[i].tx, tbl[i].exp_rx, 16'h0000, m);
            @(negedge clk);
        end

        for (int i = 0; i < 12; i++) begin
            k  = int'($urandom_range(0, 1));
            tx = 8'($urandom);
            mp = 8'($urandom);
            lb = 1'($urandom_range(0, 1));
            run_xfer(k, tx, mp, lb, 0, 16'd0, 16'd0, m);
            verify($sformatf("rnd%0d", i), k, tx, lb ? tx : mp, 16'h0000, m);
            @(negedge clk);
        end

        // CS framing with a CTRL write attempted mid-transfer.
        check("cs.before", int'(cs_n[0]), 1);
        wr(0, A_CTRL, 16'h0001);
        check("cs.asserted", int'(cs_n[0]), 0);
        rd(0, A_CTRL, v);
        check("cs.ctrl_read", int'(v), 16'h0002);
        run_xfer(0, 8'h9F, 8'h3C, 1'b0, 5, A_CTRL, 16'h0000, m);
        verify("cs_xfer", 0, 8'h9F, 8'h3C, 16'h0002, m);
        check("cs.held_during_busy", m.cs_changed, 0);
        @(negedge clk);
        wr(0, A_CTRL, 16'h0000);
        check("cs.released", int'(cs_n[0]), 1);

        // Data write during busy must be dropped.
        run_xfer(1, 8'h22, 8'hE7, 1'b0, 10, A_DATA, 16'h0011, m);
        verify("ignored_wr", 1, 8'h22, 8'hE7, 16'h0000, m);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy[1]) n++;
            @(negedge clk);
        end
        check("ignored_wr.no_second", n, 0);

        // Back-to-back: second write lands in the first idle cycle.
        run_xfer(0, 8'h5C, 8'hC5, 1'b0, 0, 16'd0, 16'd0, m);
        verify("b2b_a", 0, 8'h5C, 8'hC5, 16'h0000, m);
        run_xfer(0, 8'h3A, 8'h00, 1'b1, 0, 16'd0, 16'd0, m);
        verify("b2b_b", 0, 8'h3A, 8'h3A, 16'h0000, m);
        @(negedge clk);

        // Reset abort at bit 4 of a CLKDIV=3 transfer with CS asserted.
        wr(1, A_CTRL, 16'h0001);
        miso[1] = 1'b1;
        wr(1, A_DATA, 16'h00C3);
        n = 0;
        prev = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (sck[1] && !prev) n++;
            prev = sck[1];
            if (n == 4) break;
            @(negedge clk);
        end
        check("abort.reached_bit4", n, 4);
        resetq = 1'b0;
        #1;
        check("abort.sck", int'(sck[1]), 0);
        check("abort.cs_n", int'(cs_n[1]), 1);
        check("abort.busy", int'(busy[1]), 0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (irq[1]) n++;
            @(negedge clk);
        end
        check("abort.no_irq", n, 0);
        resetq = 1'b1;
        @(negedge clk);
        rd(1, A_DATA, v);
        check("abort.rx_cleared", int'(v), 0);
        rd(1, A_CTRL, v);
        check("abort.ctrl", int'(v), 0);

        for (int i = 0; i < 2; i++) begin
            rd(i, 16'd322, v);
            check("unmapped_read", int'(v), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
